// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - pipeline-side signal bundle for the hazard/stall controller
interface hazard_ctrl_if;
  logic [4:0]  ID_rs;
  logic [4:0]  ID_rt;
  logic        ID_UseRs;
  logic        ID_UseRt;
  logic [1:0]  ID_Branch;
  logic [1:0]  ID_Jump;
  logic        ID_Redirect;
  logic        ID_MduOp;
  logic        ID_MduRead;
  logic        EX_RegWrite;
  logic [1:0]  EX_RegSrc;
  logic [4:0]  EX_WriteReg;
  logic        MEM_RegWrite;
  logic [1:0]  MEM_RegSrc;
  logic [4:0]  MEM_WriteReg;
  logic        PC_Write;
  logic        IFID_Write;
  logic        IFID_Flush;
  logic        IDEX_Flush;
  logic        mdu_start;
  logic        mdu_busy;
  logic [31:0] stall_count;

  modport master (
    output ID_rs, ID_rt, ID_UseRs, ID_UseRt, ID_Branch, ID_Jump, ID_Redirect,
           ID_MduOp, ID_MduRead, EX_RegWrite, EX_RegSrc, EX_WriteReg,
           MEM_RegWrite, MEM_RegSrc, MEM_WriteReg,
    input  PC_Write, IFID_Write, IFID_Flush, IDEX_Flush, mdu_start, mdu_busy,
           stall_count
  );

  modport slave (
    input  ID_rs, ID_rt, ID_UseRs, ID_UseRt, ID_Branch, ID_Jump, ID_Redirect,
           ID_MduOp, ID_MduRead, EX_RegWrite, EX_RegSrc, EX_WriteReg,
           MEM_RegWrite, MEM_RegSrc, MEM_WriteReg,
    output PC_Write, IFID_Write, IFID_Flush, IDEX_Flush, mdu_start, mdu_busy,
           stall_count
  );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - ID-stage hazard/stall controller with MDU busy sequencer
module hazard_ctrl #(
  parameter int MDU_LATENCY = 32  // 2..255
) (
  input logic         clk,
  input logic         rst,
  hazard_ctrl_if.slave hz
);
  localparam logic [1:0] BRANCH_NONE = 2'd0;
  localparam logic [1:0] JUMP_REG    = 2'd2;
  localparam logic [1:0] REGSRC_ALU  = 2'd0;
  localparam logic [1:0] REGSRC_DMEM = 2'd1;

  typedef enum logic {IDLE, BUSY} mduState_e;

  mduState_e  state;
  mduState_e  stateNext;
  logic [7:0] busyCnt;
  logic       useRegAtId;
  logic       exHit;
  logic       memHit;
  logic       dataStall;
  logic       mduStall;
  logic       stall;
  logic       mduStart;

  // Hazard detection; $0 is never a real producer.
  always_comb begin
    useRegAtId = (hz.ID_Branch != BRANCH_NONE) || (hz.ID_Jump == JUMP_REG);
    exHit  = hz.EX_RegWrite && (hz.EX_WriteReg != 5'd0) &&
             ((hz.ID_UseRs && (hz.EX_WriteReg == hz.ID_rs)) ||
              (hz.ID_UseRt && (hz.EX_WriteReg == hz.ID_rt)));
    memHit = hz.MEM_RegWrite && (hz.MEM_WriteReg != 5'd0) &&
             ((hz.ID_UseRs && (hz.MEM_WriteReg == hz.ID_rs)) ||
              (hz.ID_UseRt && (hz.MEM_WriteReg == hz.ID_rt)));
    if (useRegAtId) begin
      dataStall = (exHit && ((hz.EX_RegSrc == REGSRC_ALU) || (hz.EX_RegSrc == REGSRC_DMEM))) ||
                  (memHit && (hz.MEM_RegSrc == REGSRC_DMEM));
    end else begin
      dataStall = exHit && (hz.EX_RegSrc == REGSRC_DMEM);
    end
    mduStall = (state == BUSY) && (hz.ID_MduOp || hz.ID_MduRead);
    stall    = dataStall || mduStall;
    mduStart = !rst && (state == IDLE) && hz.ID_MduOp && !dataStall;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busyCnt <= 8'd0;
    end else begin
      state <= stateNext;
      if ((state == IDLE) && mduStart) begin
        busyCnt <= 8'(MDU_LATENCY - 1);
      end else if ((state == BUSY) && (busyCnt != 8'd0)) begin
        busyCnt <= busyCnt - 8'd1;
      end
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (mduStart) stateNext = BUSY;
      BUSY:    if (busyCnt == 8'd0) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // A redirect seen during a stall is ignored: its operands were not yet valid.
  always_comb begin
    hz.PC_Write   = 1'b0;
    hz.IFID_Write = 1'b0;
    hz.IFID_Flush = 1'b1;
    hz.IDEX_Flush = 1'b1;
    hz.mdu_start  = 1'b0;
    hz.mdu_busy   = (state == BUSY);
    if (!rst) begin
      hz.PC_Write   = !stall;
      hz.IFID_Write = !stall;
      hz.IFID_Flush = !stall && hz.ID_Redirect;
      hz.IDEX_Flush = stall;
      hz.mdu_start  = mduStart;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hz.stall_count <= 32'd0;
    end else if (stall && (hz.stall_count != 32'hFFFF_FFFF)) begin
      hz.stall_count <= hz.stall_count + 32'd1;
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - randomized and directed bench for hazard_ctrl
module tb_hazard_ctrl;
  localparam int LAT = 4;
  localparam logic [1:0] BR_NONE = 2'd0, BR_BEQ = 2'd1, J_REG = 2'd2;
  localparam logic [1:0] SRC_ALU = 2'd0, SRC_DMEM = 2'd1, SRC_PC4 = 2'd2;

  typedef struct {
    logic       rst;
    logic [4:0] rs, rt;
    logic       useRs, useRt;
    logic [1:0] br, jmp;
    logic       redir, mduOp, mduRead;
    logic       exWe;
    logic [1:0] exSrc;
    logic [4:0] exWr;
    logic       memWe;
    logic [1:0] memSrc;
    logic [4:0] memWr;
  } stim_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_ctrl_if hif();
  hazard_ctrl #(.MDU_LATENCY(LAT)) dut (.clk(clk), .rst(rst), .hz(hif));

  int checks = 0;
  int errors = 0;
  longint cyc = 0;
  longint busyEnd = -1;
  longint expCount = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic stim_t blank();
    stim_t s;
    s.rst = 0; s.rs = 0; s.rt = 0; s.useRs = 0; s.useRt = 0;
    s.br = BR_NONE; s.jmp = 2'd0; s.redir = 0; s.mduOp = 0; s.mduRead = 0;
    s.exWe = 0; s.exSrc = SRC_ALU; s.exWr = 0;
    s.memWe = 0; s.memSrc = SRC_ALU; s.memWr = 0;
    return s;
  endfunction

  function automatic logic hit(logic we, logic [4:0] wr, logic [4:0] r, logic use_);
    return use_ && we && (wr != 0) && (wr == r);
  endfunction

  function automatic logic [4:0] pickReg();
    case ($urandom_range(0, 4))
      0: return 5'd0;
      1: return 5'd8;
      2: return 5'd9;
      3: return 5'd10;
      default: return 5'($urandom);
    endcase
  endfunction

  // One pipeline cycle: drive, compare against the rule model, then advance the model on the edge.
  // o = {PC_Write, IFID_Write, IFID_Flush, IDEX_Flush, mdu_start, mdu_busy}
  task automatic runCycle(input stim_t s, output logic [5:0] o);
    logic exH, memH, idCons, dStall, busy, stl, start;
    logic [5:0] exp;
    rst = s.rst;
    hif.ID_rs = s.rs; hif.ID_rt = s.rt; hif.ID_UseRs = s.useRs; hif.ID_UseRt = s.useRt;
    hif.ID_Branch = s.br; hif.ID_Jump = s.jmp; hif.ID_Redirect = s.redir;
    hif.ID_MduOp = s.mduOp; hif.ID_MduRead = s.mduRead;
    hif.EX_RegWrite = s.exWe; hif.EX_RegSrc = s.exSrc; hif.EX_WriteReg = s.exWr;
    hif.MEM_RegWrite = s.memWe; hif.MEM_RegSrc = s.memSrc; hif.MEM_WriteReg = s.memWr;
    #2;
    exH  = hit(s.exWe, s.exWr, s.rs, s.useRs) || hit(s.exWe, s.exWr, s.rt, s.useRt);
    memH = hit(s.memWe, s.memWr, s.rs, s.useRs) || hit(s.memWe, s.memWr, s.rt, s.useRt);
    idCons = (s.br != BR_NONE) || (s.jmp == J_REG);
    if (idCons)
      dStall = (exH && (s.exSrc == SRC_ALU || s.exSrc == SRC_DMEM)) || (memH && s.memSrc == SRC_DMEM);
    else
      dStall = exH && (s.exSrc == SRC_DMEM);
    busy  = (cyc <= busyEnd);
    stl   = dStall || (busy && (s.mduOp || s.mduRead));
    start = !busy && s.mduOp && !dStall;
    if (s.rst) exp = {4'b0011, 1'b0, busy};
    else       exp = {!stl, !stl, !stl && s.redir, stl, start, busy};
    o = {hif.PC_Write, hif.IFID_Write, hif.IFID_Flush, hif.IDEX_Flush, hif.mdu_start, hif.mdu_busy};
    check("outputs", 64'(o), 64'(exp));
    check("stall_count", 64'(hif.stall_count), 64'(expCount[31:0]));
    @(posedge clk);
    if (s.rst) begin
      busyEnd = -1;
      expCount = 0;
    end else begin
      if (stl && expCount < 64'hFFFF_FFFF) expCount++;
      if (start) busyEnd = cyc + LAT;
    end
    cyc++;
    #1;
  endtask

  initial begin
    stim_t s;
    logic [5:0] o;
    logic [31:0] c0;

    s = blank(); s.rst = 1;
    runCycle(s, o);
    runCycle(s, o);
    check("rst_outs", 64'(o[5:1]), 64'b00110);
    check("rst_count", 64'(hif.stall_count), 64'd0);
    s = blank();
    runCycle(s, o);
    check("idle_outs", 64'(o), 64'b110000);

    // ALU result in EX feeding beq: one stall with redirect ignored, then the redirect flushes.
    s = blank(); s.br = BR_BEQ; s.rs = 8; s.useRs = 1; s.redir = 1;
    s.exWe = 1; s.exWr = 8; s.exSrc = SRC_ALU;
    runCycle(s, o);
    check("beq_stall", 64'(o[5:2]), 64'b0001);
    s.exWe = 0; s.memWe = 1; s.memWr = 8; s.memSrc = SRC_ALU;
    runCycle(s, o);
    check("beq_redirect", 64'(o[5:2]), 64'b1110);

    // Load to $9 followed by jr $9: EX match, then MEM match.
    c0 = hif.stall_count;
    s = blank(); s.jmp = J_REG; s.rs = 9; s.useRs = 1;
    s.exWe = 1; s.exWr = 9; s.exSrc = SRC_DMEM;
    runCycle(s, o);
    check("jr_stall_ex", 64'(o[2]), 64'd1);
    s.exWe = 0; s.memWe = 1; s.memWr = 9; s.memSrc = SRC_DMEM;
    runCycle(s, o);
    check("jr_stall_mem", 64'(o[2]), 64'd1);
    s.memWe = 0;
    runCycle(s, o);
    check("jr_go", 64'(o[5]), 64'd1);
    check("jr_delta", 64'(hif.stall_count - c0), 64'd2);

    // Load-use for an EX consumer, and the same with $0 as destination.
    s = blank(); s.rs = 10; s.useRs = 1; s.exWe = 1; s.exWr = 10; s.exSrc = SRC_DMEM;
    runCycle(s, o);
    check("loaduse", 64'(o[2]), 64'd1);
    s.exWr = 0;
    runCycle(s, o);
    check("loaduse_zero", 64'(o[2]), 64'd0);

    // mult in cycle 0, mflo held from cycle 1.
    s = blank(); s.mduOp = 1;
    runCycle(s, o);
    check("mult_start", 64'(o[1:0]), 64'b10);
    s = blank(); s.mduRead = 1;
    for (int k = 1; k <= LAT; k++) begin
      runCycle(s, o);
      check("mflo_wait", 64'({o[2], o[0]}), 64'b11);
    end
    runCycle(s, o);
    check("mflo_issue", 64'({o[5], o[0]}), 64'b10);

    // New mult, unrelated add proceeds in cycle 1, reset aborts in cycle 2.
    s = blank(); s.mduOp = 1;
    runCycle(s, o);
    check("mult2_start", 64'(o[1]), 64'd1);
    s = blank();
    runCycle(s, o);
    check("add_free", 64'({o[5], o[0]}), 64'b11);
    s = blank(); s.rst = 1; s.mduOp = 1;
    runCycle(s, o);
    check("rst_busy_outs", 64'(o[5:1]), 64'b00110);
    check("rst_busy_count", 64'(hif.stall_count), 64'd0);
    s = blank(); s.mduOp = 1;
    runCycle(s, o);
    check("mult_after_rst", 64'(o[1:0]), 64'b10);
    for (int k = 0; k < LAT; k++) runCycle(blank(), o);

    // Saturation: preload near the top, then hold a load-use stall.
    force hif.stall_count = 32'hFFFF_FFFD;
    #1;
    release hif.stall_count;
    expCount = 64'hFFFF_FFFD;
    s = blank(); s.rs = 10; s.useRs = 1; s.exWe = 1; s.exWr = 10; s.exSrc = SRC_DMEM;
    for (int k = 0; k < 6; k++) runCycle(s, o);
    check("saturate", 64'(hif.stall_count), 64'hFFFF_FFFF);
    s.rst = 1;
    runCycle(s, o);

    for (int n = 0; n < 3000; n++) begin
      s = blank();
      s.rst = ($urandom_range(0, 49) == 0);
      s.rs = pickReg(); s.rt = pickReg();
      s.useRs = 1'($urandom); s.useRt = 1'($urandom);
      s.br = ($urandom_range(0, 2) == 0) ? BR_BEQ : BR_NONE;
      s.jmp = 2'($urandom_range(0, 3));
      s.redir = 1'($urandom);
      s.mduOp = ($urandom_range(0, 5) == 0);
      s.mduRead = ($urandom_range(0, 5) == 0);
      s.exWe = 1'($urandom); s.exWr = pickReg(); s.exSrc = 2'($urandom_range(0, 2));
      s.memWe = 1'($urandom); s.memWr = pickReg(); s.memSrc = 2'($urandom_range(0, 2));
      runCycle(s, o);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
